// File: rtl/ndn_mcu_spi_rx.sv
// SPI-slave frame receiver: deserialises MCU Interest/Data frames into parallel
// prefix/content fields and hands them to the router over valid/ready.
module ndn_mcu_spi_rx #(
    parameter int unsigned PREFIX_BYTES  = 8,
    parameter int unsigned CONTENT_BYTES = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk_from_mcu,
    input  logic                       cs_from_mcu,
    input  logic                       mosi_from_mcu,
    output logic                       miso_to_mcu,
    output logic                       pkt_valid,
    input  logic                       pkt_ready,
    output logic                       pkt_is_data,
    output logic [8*PREFIX_BYTES-1:0]  prefix,
    output logic [3:0]                 prefix_len,
    output logic [8*CONTENT_BYTES-1:0] content,
    output logic [7:0]                 content_len,
    output logic                       err,
    output logic [2:0]                 err_code
);

    localparam int unsigned PFX_W   = 8 * PREFIX_BYTES;
    localparam int unsigned CNT_W   = 8 * CONTENT_BYTES;
    localparam logic [7:0]  PFX_MAX = 8'(PREFIX_BYTES);
    localparam logic [7:0]  CNT_MAX = 8'(CONTENT_BYTES);

    localparam logic [2:0] S_WAIT_CS = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_HDR     = 3'd2;
    localparam logic [2:0] S_PREFIX  = 3'd3;
    localparam logic [2:0] S_CLEN    = 3'd4;
    localparam logic [2:0] S_CONTENT = 3'd5;
    localparam logic [2:0] S_DROP    = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    localparam logic [2:0] E_TYPE    = 3'd1;
    localparam logic [2:0] E_LEN     = 3'd2;
    localparam logic [2:0] E_TRUNC   = 3'd3;
    localparam logic [2:0] E_OVERRUN = 3'd4;

    // synchroniser / edge-detect stages
    logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic r_cs_s1, r_cs_s2, r_cs_s3;
    logic r_mosi_s1, r_mosi_s2;

    // frame assembly state
    logic [2:0]       r_state;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_byte_cnt;
    logic [6:0]       r_shift;
    logic             r_is_data;
    logic [3:0]       r_n;
    logic [7:0]       r_m;
    logic [PFX_W-1:0] r_pfx_buf;
    logic [CNT_W-1:0] r_cnt_buf;

    // registered packet outputs
    logic             r_pkt_valid;
    logic             r_miso;
    logic             r_pkt_is_data;
    logic [PFX_W-1:0] r_prefix;
    logic [3:0]       r_prefix_len;
    logic [CNT_W-1:0] r_content;
    logic [7:0]       r_content_len;
    logic             r_err;
    logic [2:0]       r_err_code;

    // next-state values
    logic [2:0]       w_state_nx;
    logic [2:0]       w_bit_cnt_nx;
    logic [7:0]       w_byte_cnt_nx;
    logic [6:0]       w_shift_nx;
    logic             w_is_data_nx;
    logic [3:0]       w_n_nx;
    logic [7:0]       w_m_nx;
    logic [PFX_W-1:0] w_pfx_buf_nx;
    logic [CNT_W-1:0] w_cnt_buf_nx;
    logic             w_valid_nx;
    logic             w_miso_nx;
    logic             w_out_data_nx;
    logic [PFX_W-1:0] w_prefix_nx;
    logic [3:0]       w_plen_nx;
    logic [CNT_W-1:0] w_content_nx;
    logic [7:0]       w_clen_nx;
    logic             w_err_nx;
    logic [2:0]       w_err_code_nx;
    logic             w_commit;
    logic [7:0]       w_byte_inc;

    logic       w_sclk_rise;
    logic       w_cs_fall;
    logic       w_cs_rise;
    logic       w_byte_done;
    logic [7:0] w_byte;

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
    assign w_cs_fall   = ~r_cs_s2 & r_cs_s3;
    assign w_cs_rise   = r_cs_s2 & ~r_cs_s3;
    assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7);
    assign w_byte      = {r_shift, r_mosi_s2};

    // Two-flop synchronisers plus a third sclk/cs stage for edge detection.
    // cs stages reset low so a frame already in progress never looks like a fresh cs fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_s3 <= 1'b0;
            r_cs_s1   <= 1'b0;
            r_cs_s2   <= 1'b0;
            r_cs_s3   <= 1'b0;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
        end else begin
            r_sclk_s1 <= sclk_from_mcu;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_s3 <= r_sclk_s2;
            r_cs_s1   <= cs_from_mcu;
            r_cs_s2   <= r_cs_s1;
            r_cs_s3   <= r_cs_s2;
            r_mosi_s1 <= mosi_from_mcu;
            r_mosi_s2 <= r_mosi_s1;
        end
    end

    // Next-state and output logic; commit uses the buffers including the byte landing this cycle.
    always_comb begin
        w_state_nx    = r_state;
        w_bit_cnt_nx  = r_bit_cnt;
        w_byte_cnt_nx = r_byte_cnt;
        w_shift_nx    = r_shift;
        w_is_data_nx  = r_is_data;
        w_n_nx        = r_n;
        w_m_nx        = r_m;
        w_pfx_buf_nx  = r_pfx_buf;
        w_cnt_buf_nx  = r_cnt_buf;
        w_valid_nx    = r_pkt_valid;
        w_miso_nx     = r_miso;
        w_out_data_nx = r_pkt_is_data;
        w_prefix_nx   = r_prefix;
        w_plen_nx     = r_prefix_len;
        w_content_nx  = r_content;
        w_clen_nx     = r_content_len;
        w_err_nx      = 1'b0;
        w_err_code_nx = r_err_code;
        w_commit      = 1'b0;
        w_byte_inc    = r_byte_cnt + 8'd1;

        if (r_pkt_valid && pkt_ready) begin
            w_valid_nx = 1'b0;
            w_miso_nx  = 1'b0;
        end

        if (w_sclk_rise) begin
            w_shift_nx   = {r_shift[5:0], r_mosi_s2};
            w_bit_cnt_nx = r_bit_cnt + 3'd1;
        end

        case (r_state)
            S_WAIT_CS: begin
                if (r_cs_s2) begin
                    w_state_nx = S_IDLE;
                end
            end
            S_IDLE: begin
                if (w_cs_fall) begin
                    if (r_pkt_valid && !pkt_ready) begin
                        w_state_nx    = S_DROP;
                        w_err_nx      = 1'b1;
                        w_err_code_nx = E_OVERRUN;
                    end else begin
                        w_state_nx    = S_HDR;
                        w_bit_cnt_nx  = 3'd0;
                        w_byte_cnt_nx = 8'd0;
                        w_m_nx        = 8'd0;
                        w_pfx_buf_nx  = '0;
                        w_cnt_buf_nx  = '0;
                    end
                end
            end
            S_HDR: begin
                if (w_cs_rise) begin
                    w_state_nx    = S_IDLE;
                    w_err_nx      = 1'b1;
                    w_err_code_nx = E_TRUNC;
                end else if (w_byte_done) begin
                    w_is_data_nx  = w_byte[7];
                    w_n_nx        = w_byte[3:0];
                    w_byte_cnt_nx = 8'd0;
                    if (w_byte[7] == w_byte[6]) begin
                        w_state_nx    = S_DROP;
                        w_err_nx      = 1'b1;
                        w_err_code_nx = E_TYPE;
                    end else if ((w_byte[3:0] == 4'd0) || (8'(w_byte[3:0]) > PFX_MAX)) begin
                        w_state_nx    = S_DROP;
                        w_err_nx      = 1'b1;
                        w_err_code_nx = E_LEN;
                    end else begin
                        w_state_nx = S_PREFIX;
                    end
                end
            end
            S_PREFIX: begin
                if (w_cs_rise) begin
                    w_state_nx    = S_IDLE;
                    w_err_nx      = 1'b1;
                    w_err_code_nx = E_TRUNC;
                end else if (w_byte_done) begin
                    for (int i = 0; i < int'(PREFIX_BYTES); i++) begin
                        if (r_byte_cnt == 8'(i)) begin
                            w_pfx_buf_nx[PFX_W-1-8*i -: 8] = w_byte;
                        end
                    end
                    w_byte_cnt_nx = w_byte_inc;
                    if (w_byte_inc == 8'(r_n)) begin
                        if (r_is_data) begin
                            w_state_nx = S_CLEN;
                        end else begin
                            w_commit = 1'b1;
                        end
                    end
                end
            end
            S_CLEN: begin
                if (w_cs_rise) begin
                    w_state_nx    = S_IDLE;
                    w_err_nx      = 1'b1;
                    w_err_code_nx = E_TRUNC;
                end else if (w_byte_done) begin
                    w_m_nx        = w_byte;
                    w_byte_cnt_nx = 8'd0;
                    if (w_byte > CNT_MAX) begin
                        w_state_nx    = S_DROP;
                        w_err_nx      = 1'b1;
                        w_err_code_nx = E_LEN;
                    end else if (w_byte == 8'd0) begin
                        w_commit = 1'b1;
                    end else begin
                        w_state_nx = S_CONTENT;
                    end
                end
            end
            S_CONTENT: begin
                if (w_cs_rise) begin
                    w_state_nx    = S_IDLE;
                    w_err_nx      = 1'b1;
                    w_err_code_nx = E_TRUNC;
                end else if (w_byte_done) begin
                    for (int i = 0; i < int'(CONTENT_BYTES); i++) begin
                        if (r_byte_cnt == 8'(i)) begin
                            w_cnt_buf_nx[CNT_W-1-8*i -: 8] = w_byte;
                        end
                    end
                    w_byte_cnt_nx = w_byte_inc;
                    if (w_byte_inc == r_m) begin
                        w_commit = 1'b1;
                    end
                end
            end
            S_DROP, S_DONE: begin
                if (w_cs_rise) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_WAIT_CS;
            end
        endcase

        if (w_commit) begin
            w_state_nx    = S_DONE;
            w_valid_nx    = 1'b1;
            w_miso_nx     = 1'b1;
            w_out_data_nx = r_is_data;
            w_prefix_nx   = w_pfx_buf_nx;
            w_plen_nx     = r_n;
            w_content_nx  = w_cnt_buf_nx;
            w_clen_nx     = w_m_nx;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_WAIT_CS;
            r_bit_cnt     <= 3'd0;
            r_byte_cnt    <= 8'd0;
            r_shift       <= 7'd0;
            r_is_data     <= 1'b0;
            r_n           <= 4'd0;
            r_m           <= 8'd0;
            r_pfx_buf     <= '0;
            r_cnt_buf     <= '0;
            r_pkt_valid   <= 1'b0;
            r_miso        <= 1'b0;
            r_pkt_is_data <= 1'b0;
            r_prefix      <= '0;
            r_prefix_len  <= 4'd0;
            r_content     <= '0;
            r_content_len <= 8'd0;
            r_err         <= 1'b0;
            r_err_code    <= 3'd0;
        end else begin
            r_state       <= w_state_nx;
            r_bit_cnt     <= w_bit_cnt_nx;
            r_byte_cnt    <= w_byte_cnt_nx;
            r_shift       <= w_shift_nx;
            r_is_data     <= w_is_data_nx;
            r_n           <= w_n_nx;
            r_m           <= w_m_nx;
            r_pfx_buf     <= w_pfx_buf_nx;
            r_cnt_buf     <= w_cnt_buf_nx;
            r_pkt_valid   <= w_valid_nx;
            r_miso        <= w_miso_nx;
            r_pkt_is_data <= w_out_data_nx;
            r_prefix      <= w_prefix_nx;
            r_prefix_len  <= w_plen_nx;
            r_content     <= w_content_nx;
            r_content_len <= w_clen_nx;
            r_err         <= w_err_nx;
            r_err_code    <= w_err_code_nx;
        end
    end

    assign miso_to_mcu = r_miso;
    assign pkt_valid   = r_pkt_valid;
    assign pkt_is_data = r_pkt_is_data;
    assign prefix      = r_prefix;
    assign prefix_len  = r_prefix_len;
    assign content     = r_content;
    assign content_len = r_content_len;
    assign err         = r_err;
    assign err_code    = r_err_code;

endmodule

// File: tb/tb_ndn_mcu_spi_rx.sv
// Testbench for ndn_mcu_spi_rx: directed frames from the test plan plus random
// frames checked against a byte-level frame decoder model.
module tb_ndn_mcu_spi_rx;

    localparam int unsigned PB = 8;
    localparam int unsigned CB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, sclk_from_mcu, cs_from_mcu, mosi_from_mcu, pkt_ready;
    logic        miso_to_mcu, pkt_valid, pkt_is_data, err;
    logic [63:0] prefix, content;
    logic [3:0]  prefix_len;
    logic [7:0]  content_len;
    logic [2:0]  err_code;

    ndn_mcu_spi_rx #(.PREFIX_BYTES(PB), .CONTENT_BYTES(CB)) dut (
        .clk(clk), .rst(rst),
        .sclk_from_mcu(sclk_from_mcu), .cs_from_mcu(cs_from_mcu), .mosi_from_mcu(mosi_from_mcu),
        .miso_to_mcu(miso_to_mcu), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_is_data(pkt_is_data), .prefix(prefix), .prefix_len(prefix_len),
        .content(content), .content_len(content_len), .err(err), .err_code(err_code)
    );

    int total = 0;
    int bad   = 0;

    // event monitor: error pulses and pkt_valid rising edges
    int         mon_err = 0;
    int         mon_commit = 0;
    logic       mon_prev = 1'b0;
    always @(negedge clk) begin
        if (err) mon_err <= mon_err + 1;
        if (pkt_valid && !mon_prev) mon_commit <= mon_commit + 1;
        mon_prev <= pkt_valid;
    end

    logic [7:0] tx_q[$];
    int         lat_cnt;

    // expected visible packet state
    logic        x_valid, x_data;
    logic [63:0] x_pfx, x_cnt;
    logic [3:0]  x_plen;
    logic [7:0]  x_clen;
    logic [2:0]  x_code;

    task automatic spi_bit(input logic b);
        logic pv0;
        mosi_from_mcu = b;
        repeat (3) @(negedge clk);
        sclk_from_mcu = 1'b1;
        pv0 = pkt_valid;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            if (!pv0 && pkt_valid && lat_cnt == 99) lat_cnt = k;
            @(negedge clk);
        end
        sclk_from_mcu = 1'b0;
    endtask

    task automatic spi_end();
        repeat (3) @(negedge clk);
        cs_from_mcu   = 1'b1;
        mosi_from_mcu = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_frame(input int extra_bits, input bit do_end);
        lat_cnt = 99;
        @(negedge clk);
        cs_from_mcu = 1'b0;
        foreach (tx_q[i]) for (int j = 7; j >= 0; j--) spi_bit(tx_q[i][j]);
        for (int e = 0; e < extra_bits; e++) spi_bit(1'($urandom_range(0, 1)));
        if (do_end) spi_end();
    endtask

    task automatic ack();
        @(negedge clk); pkt_ready = 1'b1;
        @(negedge clk); pkt_ready = 1'b0;
        x_valid = 1'b0;
    endtask

    // Frame decoder over the complete bytes in tx_q: kind 0 = commit, else error code.
    task automatic model(input bit pending, output int kind, output logic d,
                         output logic [63:0] p, output logic [3:0] pl,
                         output logic [63:0] c, output logic [7:0] cl);
        int n, m;
        logic [7:0] h;
        kind = 0; d = 1'b0; p = '0; pl = '0; c = '0; cl = '0;
        if (pending) begin kind = 4; return; end
        if (tx_q.size() < 1) begin kind = 3; return; end
        h = tx_q[0];
        n = int'(h[3:0]);
        if (h[7:6] == 2'b00 || h[7:6] == 2'b11) begin kind = 1; return; end
        if (n == 0 || n > int'(PB)) begin kind = 2; return; end
        if (tx_q.size() < 1 + n) begin kind = 3; return; end
        d  = (h[7:6] == 2'b10);
        pl = h[3:0];
        for (int i = 0; i < n; i++) p = p | ({tx_q[1+i], 56'h0} >> (8 * i));
        if (!d) return;
        if (tx_q.size() < 2 + n) begin kind = 3; return; end
        m = int'(tx_q[1+n]);
        if (m > int'(CB)) begin kind = 2; return; end
        if (tx_q.size() < 2 + n + m) begin kind = 3; return; end
        cl = tx_q[1+n];
        for (int i = 0; i < m; i++) c = c | ({tx_q[2+n+i], 56'h0} >> (8 * i));
    endtask

    task automatic test_reset();
        total++;
        if ({pkt_valid, miso_to_mcu, pkt_is_data, prefix_len, content_len, err, err_code} !== 19'd0) begin
            bad++;
            $display("FAIL reset_status: got %h want 0",
                     {pkt_valid, miso_to_mcu, pkt_is_data, prefix_len, content_len, err, err_code});
        end
        total++;
        if ({prefix, content} !== 128'd0) begin
            bad++; $display("FAIL reset_fields: got %h/%h want 0/0", prefix, content);
        end
        @(negedge clk); rst = 1'b0;
        repeat (6) @(negedge clk);
        total++;
        if (pkt_valid !== 1'b0 || mon_err != 0) begin
            bad++; $display("FAIL reset_release: valid=%b errs=%0d want 0/0", pkt_valid, mon_err);
        end
    endtask

    task automatic test_interest();
        int c0, e0;
        c0 = mon_commit; e0 = mon_err;
        tx_q = '{8'h43, 8'hDE, 8'hAD, 8'hBE};
        send_frame(0, 1);
        total++;
        if (!(lat_cnt >= 1 && lat_cnt <= 4)) begin
            bad++; $display("FAIL interest_latency: got %0d cycles want 1..4", lat_cnt);
        end
        total++;
        if (mon_commit - c0 != 1 || mon_err - e0 != 0) begin
            bad++; $display("FAIL interest_events: commits=%0d errs=%0d want 1/0", mon_commit - c0, mon_err - e0);
        end
        total++;
        if ({pkt_valid, miso_to_mcu, pkt_is_data, prefix_len, content_len} !== {1'b1, 1'b1, 1'b0, 4'd3, 8'd0}) begin
            bad++; $display("FAIL interest_status: got v=%b m=%b d=%b pl=%0d cl=%0d want 1 1 0 3 0",
                            pkt_valid, miso_to_mcu, pkt_is_data, prefix_len, content_len);
        end
        total++;
        if (prefix !== 64'hDEADBE0000000000 || content !== 64'd0) begin
            bad++; $display("FAIL interest_fields: got %h/%h want deadbe0000000000/0", prefix, content);
        end
        ack();
        total++;
        if (pkt_valid !== 1'b0 || miso_to_mcu !== 1'b0 || prefix !== 64'hDEADBE0000000000) begin
            bad++; $display("FAIL interest_ack: got v=%b m=%b p=%h want 0 0 deadbe0000000000",
                            pkt_valid, miso_to_mcu, prefix);
        end
    endtask

    task automatic test_data();
        tx_q = '{8'h82, 8'h11, 8'h22, 8'h02, 8'hAB, 8'hCD};
        send_frame(0, 1);
        total++;
        if ({pkt_valid, pkt_is_data, prefix_len, content_len} !== {1'b1, 1'b1, 4'd2, 8'd2} ||
            prefix !== 64'h1122000000000000 || content !== 64'hABCD000000000000) begin
            bad++; $display("FAIL data_frame: got v=%b d=%b pl=%0d cl=%0d p=%h c=%h want 1 1 2 2 1122.. abcd..",
                            pkt_valid, pkt_is_data, prefix_len, content_len, prefix, content);
        end
        ack();
        tx_q = '{8'h82, 8'h11, 8'h22, 8'h00};
        send_frame(0, 1);
        total++;
        if (!(lat_cnt >= 1 && lat_cnt <= 4)) begin
            bad++; $display("FAIL data_clen0_latency: got %0d want 1..4", lat_cnt);
        end
        total++;
        if ({pkt_valid, pkt_is_data, prefix_len, content_len} !== {1'b1, 1'b1, 4'd2, 8'd0} ||
            prefix !== 64'h1122000000000000 || content !== 64'd0) begin
            bad++; $display("FAIL data_clen0: got v=%b d=%b pl=%0d cl=%0d p=%h c=%h want 1 1 2 0 1122.. 0",
                            pkt_valid, pkt_is_data, prefix_len, content_len, prefix, content);
        end
        ack();
    endtask

    task automatic test_errors();
        logic [7:0] frames[3][3];
        int         lens[3];
        logic [2:0] codes[3];
        int         c0, e0;
        frames[0] = '{8'hC1, 8'h00, 8'h00}; lens[0] = 1; codes[0] = 3'd1;
        frames[1] = '{8'h49, 8'h00, 8'h00}; lens[1] = 1; codes[1] = 3'd2;
        frames[2] = '{8'h81, 8'h55, 8'h09}; lens[2] = 3; codes[2] = 3'd2;
        for (int f = 0; f < 3; f++) begin
            tx_q.delete();
            for (int b = 0; b < lens[f]; b++) tx_q.push_back(frames[f][b]);
            c0 = mon_commit; e0 = mon_err;
            send_frame(0, 1);
            total++;
            if (mon_err - e0 != 1 || err_code !== codes[f] || mon_commit - c0 != 0 || pkt_valid !== 1'b0) begin
                bad++; $display("FAIL error_frame%0d: errs=%0d code=%0d commits=%0d v=%b want 1 %0d 0 0",
                                f, mon_err - e0, err_code, mon_commit - c0, pkt_valid, codes[f]);
            end
        end
        tx_q = '{8'h41, 8'h77};
        c0 = mon_commit; e0 = mon_err;
        send_frame(0, 1);
        total++;
        if (mon_commit - c0 != 1 || mon_err - e0 != 0 || prefix !== 64'h7700000000000000 || prefix_len !== 4'd1) begin
            bad++; $display("FAIL error_recover: commits=%0d errs=%0d p=%h pl=%0d want 1 0 7700.. 1",
                            mon_commit - c0, mon_err - e0, prefix, prefix_len);
        end
        ack();
    endtask

    task automatic test_truncate();
        int e0;
        tx_q = '{8'h44, 8'hDE, 8'hAD};
        e0 = mon_err;
        send_frame(3, 1);
        total++;
        if (mon_err - e0 != 1 || err_code !== 3'd3) begin
            bad++; $display("FAIL truncate_err: errs=%0d code=%0d want 1 3", mon_err - e0, err_code);
        end
        total++;
        if (pkt_valid !== 1'b0 || prefix !== 64'h7700000000000000 || prefix_len !== 4'd1 || pkt_is_data !== 1'b0) begin
            bad++; $display("FAIL truncate_hold: v=%b p=%h pl=%0d d=%b want 0 7700.. 1 0",
                            pkt_valid, prefix, prefix_len, pkt_is_data);
        end
    endtask

    task automatic test_overrun();
        int c0, e0;
        tx_q = '{8'h41, 8'h5A};
        send_frame(0, 1);
        tx_q = '{8'h42, 8'h01, 8'h02};
        c0 = mon_commit; e0 = mon_err;
        send_frame(0, 1);
        total++;
        if (mon_err - e0 != 1 || err_code !== 3'd4 || pkt_valid !== 1'b1 || prefix !== 64'h5A00000000000000) begin
            bad++; $display("FAIL overrun_held: errs=%0d code=%0d v=%b p=%h want 1 4 1 5a00..",
                            mon_err - e0, err_code, pkt_valid, prefix);
        end
        e0 = mon_err;
        fork
            send_frame(0, 1);
            begin
                repeat (40) @(negedge clk);
                pkt_ready = 1'b1;
                @(negedge clk);
                pkt_ready = 1'b0;
            end
        join
        total++;
        if (mon_err - e0 != 1 || mon_commit - c0 != 0 || pkt_valid !== 1'b0 || miso_to_mcu !== 1'b0 ||
            prefix !== 64'h5A00000000000000) begin
            bad++; $display("FAIL overrun_no_rescue: errs=%0d commits=%0d v=%b m=%b p=%h want 1 0 0 0 5a00..",
                            mon_err - e0, mon_commit - c0, pkt_valid, miso_to_mcu, prefix);
        end
        send_frame(0, 1);
        total++;
        if (mon_commit - c0 != 1 || pkt_valid !== 1'b1 || prefix !== 64'h0102000000000000 || prefix_len !== 4'd2) begin
            bad++; $display("FAIL overrun_resend: commits=%0d v=%b p=%h pl=%0d want 1 1 0102.. 2",
                            mon_commit - c0, pkt_valid, prefix, prefix_len);
        end
        ack();
    endtask

    task automatic test_reset_midframe();
        int c0, e0;
        tx_q = '{8'h44, 8'hDE};
        send_frame(0, 0);
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        c0 = mon_commit; e0 = mon_err;
        tx_q = '{8'hAD, 8'hBE, 8'hCC};
        send_frame(0, 0);
        total++;
        if (mon_commit - c0 != 0 || mon_err - e0 != 0 || pkt_valid !== 1'b0 || prefix !== 64'd0 || err_code !== 3'd0) begin
            bad++; $display("FAIL rst_mid_frame: commits=%0d errs=%0d v=%b p=%h code=%0d want 0 0 0 0 0",
                            mon_commit - c0, mon_err - e0, pkt_valid, prefix, err_code);
        end
        spi_end();
        tx_q = '{8'h42, 8'h12, 8'h34};
        send_frame(0, 1);
        total++;
        if (mon_commit - c0 != 1 || mon_err - e0 != 0 || prefix !== 64'h1234000000000000 || prefix_len !== 4'd2) begin
            bad++; $display("FAIL rst_recover: commits=%0d errs=%0d p=%h pl=%0d want 1 0 1234.. 2",
                            mon_commit - c0, mon_err - e0, prefix, prefix_len);
        end
        ack();
        x_valid = 1'b0; x_data = 1'b0; x_pfx = 64'h1234000000000000; x_plen = 4'd2;
        x_cnt = '0; x_clen = '0; x_code = 3'd0;
    endtask

    task automatic test_random();
        int kind, n, m, r, keep, extra, c0, e0;
        logic [1:0]  typ;
        logic        d;
        logic [63:0] p, c;
        logic [3:0]  pl;
        logic [7:0]  cl;
        for (int it = 0; it < 40; it++) begin
            if (x_valid && $urandom_range(0, 9) < 7) ack();
            r   = $urandom_range(0, 9);
            typ = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
            r   = $urandom_range(0, 19);
            n   = (r == 0) ? 0 : (r == 1) ? $urandom_range(9, 15) : $urandom_range(1, 8);
            tx_q.delete();
            tx_q.push_back({typ, 2'($urandom_range(0, 3)), 4'(n)});
            for (int i = 0; i < ((n > 8) ? 2 : n); i++) tx_q.push_back(8'($urandom));
            if (typ == 2'b10) begin
                r = $urandom_range(0, 9);
                m = (r == 0) ? $urandom_range(9, 255) : $urandom_range(0, 8);
                tx_q.push_back(8'(m));
                for (int i = 0; i < ((m > 8) ? 1 : m); i++) tx_q.push_back(8'($urandom));
            end
            extra = 0;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                keep = $urandom_range(0, tx_q.size() - 1);
                while (tx_q.size() > keep) void'(tx_q.pop_back());
                extra = $urandom_range(0, 7);
            end else if (r < 4) begin
                tx_q.push_back(8'($urandom));
            end
            model(x_valid, kind, d, p, pl, c, cl);
            c0 = mon_commit; e0 = mon_err;
            send_frame(extra, 1);
            if (kind == 0) begin
                x_valid = 1'b1; x_data = d; x_pfx = p; x_plen = pl; x_cnt = c; x_clen = cl;
            end else begin
                x_code = 3'(kind);
            end
            total++;
            if (mon_commit - c0 != ((kind == 0) ? 1 : 0) || mon_err - e0 != ((kind == 0) ? 0 : 1)) begin
                bad++; $display("FAIL rand%0d_events: commits=%0d errs=%0d want kind %0d",
                                it, mon_commit - c0, mon_err - e0, kind);
            end
            total++;
            if ({pkt_valid, miso_to_mcu, pkt_is_data, prefix_len, content_len, err_code} !==
                {x_valid, x_valid, x_data, x_plen, x_clen, x_code}) begin
                bad++; $display("FAIL rand%0d_status: got %h want %h", it,
                                {pkt_valid, miso_to_mcu, pkt_is_data, prefix_len, content_len, err_code},
                                {x_valid, x_valid, x_data, x_plen, x_clen, x_code});
            end
            total++;
            if (prefix !== x_pfx || content !== x_cnt) begin
                bad++; $display("FAIL rand%0d_fields: got %h/%h want %h/%h", it, prefix, content, x_pfx, x_cnt);
            end
        end
    endtask

    initial begin
        rst = 1'b1; sclk_from_mcu = 1'b0; cs_from_mcu = 1'b1; mosi_from_mcu = 1'b0; pkt_ready = 1'b0;
        x_valid = 1'b0; x_data = 1'b0; x_pfx = '0; x_plen = '0; x_cnt = '0; x_clen = '0; x_code = '0;
        repeat (4) @(negedge clk);
        test_reset();
        test_interest();
        test_data();
        test_errors();
        test_truncate();
        test_overrun();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
